// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S receive-path types and constants
package i2s_pkg;

  localparam int I2S_DAT_WDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [I2S_DAT_WDTH-1:0] left;
    logic [I2S_DAT_WDTH-1:0] right;
  } frame_t;

endpackage

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - synchronous first-word-fall-through frame buffer
module frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// rtl/i2s_rx_ctrl.sv - qualifies receiver frames and serialises them as left/right words
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int DAT_WDTH      = I2S_DAT_WDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int WARMUP_FRAMES = 2,
  parameter int CNT_WDTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DAT_WDTH-1:0] left_chan,
  input  logic [DAT_WDTH-1:0] right_chan,
  input  logic                dump,
  output logic [DAT_WDTH-1:0] m_data,
  output logic                m_chan,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNT_WDTH-1:0] overflow_cnt,
  output logic                running
);

  localparam int WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_FRAMES);
  localparam state_t ENTRY_ST = (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WARM_W-1:0]     r_warm;
  logic                  r_phase;
  logic [CNT_WDTH-1:0]   r_ovf;
  logic                  r_running;

  logic                  w_load_warm;
  logic                  w_dec_warm;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [2*DAT_WDTH-1:0] w_head;

  frame_fifo #(
    .WIDTH (2 * DAT_WDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({left_chan, right_chan}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load_warm = 1'b0;
    w_dec_warm  = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ENTRY_ST;
          w_load_warm = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (dump) begin
          w_dec_warm = 1'b1;
          if (r_warm == WARM_W'(1)) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_DRAIN;
        end else if (dump) begin
          // Fullness is taken before any same-cycle pop, so a pop never makes room.
          w_push = !w_full;
          w_drop = w_full;
        end
      end
      ST_DRAIN: begin
        if (w_empty && !r_phase) begin
          if (enable) begin
            w_state_nxt = ENTRY_ST;
            w_load_warm = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_xfer = m_valid && m_ready;
  assign w_pop  = w_xfer && r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_warm    <= '0;
      r_phase   <= 1'b0;
      r_ovf     <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      if (w_load_warm) begin
        r_warm <= WARM_INIT;
      end else if (w_dec_warm) begin
        r_warm <= r_warm - 1'b1;
      end
      if (w_xfer) begin
        r_phase <= ~r_phase;
      end
      if (w_drop && (r_ovf != '1)) begin
        r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  assign m_valid      = !w_empty;
  assign m_chan       = r_phase;
  assign m_data       = w_empty ? '0 :
                        (r_phase ? w_head[DAT_WDTH-1:0] : w_head[2*DAT_WDTH-1:DAT_WDTH]);
  assign overflow_cnt = r_ovf;
  assign running      = r_running;

endmodule
